// File: rtl/data_sync_pkg.sv
// Shared types and limits for the toggle-handshake CDC receiver.
// Provides the FSM state encoding and the synchroniser depth range check.
package data_sync_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  localparam int NUM_STAGES_MIN = 2;
  localparam int NUM_STAGES_MAX = 4;

  function automatic bit stages_ok(input int n);
    return (n >= NUM_STAGES_MIN) && (n <= NUM_STAGES_MAX);
  endfunction

endpackage

// File: rtl/data_sync_ctrl_req_sync_chain.sv
// Multi-flop synchroniser for an asynchronous level/toggle signal.
// Ports: CLK, RST (async high), D (async input), Q (synchronised output).
module req_sync_chain #(
  parameter int NUM_STAGES = 2,
  parameter int WIDTH      = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] ff [NUM_STAGES];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NUM_STAGES; i++)
        ff[i] <= '0;
    end else begin
      ff[0] <= D;
      for (int i = 1; i < NUM_STAGES; i++)
        ff[i] <= ff[i-1];
    end
  end

  assign Q = ff[NUM_STAGES-1];

endmodule

// File: rtl/data_sync_ctrl.sv
// Destination side of a 2-phase toggle CDC: captures the source bus,
// presents it on VALID/READY, returns ACK_TGL, flags overruns, counts words.
// Ports: CLK, RST, UNSYNC_BUS, REQ_TGL in; SYNC_BUS, VALID, ACK_TGL,
// BUSY, OVERRUN, XFER_CNT out; READY, CLR_OVR in.
module data_sync_ctrl
  import data_sync_pkg::*;
#(
  parameter int NUM_STAGES = 2,
  parameter int BUS_WIDTH  = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] UNSYNC_BUS,
  input  logic                 REQ_TGL,
  output logic [BUS_WIDTH-1:0] SYNC_BUS,
  output logic                 VALID,
  input  logic                 READY,
  output logic                 ACK_TGL,
  output logic                 BUSY,
  output logic                 OVERRUN,
  input  logic                 CLR_OVR,
  output logic [CNT_WIDTH-1:0] XFER_CNT
);

  if (!stages_ok(NUM_STAGES)) begin : g_bad_stages
    $error("data_sync_ctrl: NUM_STAGES out of range 2..4");
  end

  logic   req_s;
  logic   req_d;
  logic   req_edge;
  state_t state_q;
  state_t state_d;
  logic   capture;
  logic   consume;
  logic   ovr_set;

  req_sync_chain #(
    .NUM_STAGES(NUM_STAGES),
    .WIDTH     (1)
  ) u_req_sync (
    .CLK(CLK),
    .RST(RST),
    .D  (REQ_TGL),
    .Q  (req_s)
  );

  assign req_edge = req_s ^ req_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    consume = 1'b0;
    ovr_set = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_edge) begin
          capture = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // An edge here is a new word the source sent too early; drop it.
        ovr_set = req_edge;
        if (READY) begin
          consume = 1'b1;
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      req_d    <= 1'b0;
      SYNC_BUS <= '0;
      ACK_TGL  <= 1'b0;
      OVERRUN  <= 1'b0;
      XFER_CNT <= '0;
    end else begin
      req_d <= req_s;
      if (capture)
        SYNC_BUS <= UNSYNC_BUS;
      if (consume) begin
        ACK_TGL  <= ~ACK_TGL;
        XFER_CNT <= XFER_CNT + CNT_WIDTH'(1);
      end
      // Set has priority over clear.
      if (ovr_set)
        OVERRUN <= 1'b1;
      else if (CLR_OVR)
        OVERRUN <= 1'b0;
    end
  end

  assign VALID = (state_q == ST_HOLD);
  assign BUSY  = (state_q == ST_HOLD);

endmodule

// File: tb/tb_data_sync_ctrl.sv
// Self-checking bench for data_sync_ctrl: directed, table and random tests.
// Instance a uses NUM_STAGES=2, instance b uses NUM_STAGES=3.
module tb_data_sync_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] bus_a, sync_a, cnt_a;
  logic       req_a, ready_a, clr_a;
  logic       valid_a, ack_a, busy_a, ovr_a;
  logic [7:0] bus_b, sync_b, cnt_b;
  logic       req_b, ready_b, clr_b;
  logic       valid_b, ack_b, busy_b, ovr_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_sync_ctrl #(.NUM_STAGES(2)) dut_a (
    .CLK(clk), .RST(rst), .UNSYNC_BUS(bus_a), .REQ_TGL(req_a),
    .SYNC_BUS(sync_a), .VALID(valid_a), .READY(ready_a),
    .ACK_TGL(ack_a), .BUSY(busy_a), .OVERRUN(ovr_a),
    .CLR_OVR(clr_a), .XFER_CNT(cnt_a)
  );

  data_sync_ctrl #(.NUM_STAGES(3)) dut_b (
    .CLK(clk), .RST(rst), .UNSYNC_BUS(bus_b), .REQ_TGL(req_b),
    .SYNC_BUS(sync_b), .VALID(valid_b), .READY(ready_b),
    .ACK_TGL(ack_b), .BUSY(busy_b), .OVERRUN(ovr_b),
    .CLR_OVR(clr_b), .XFER_CNT(cnt_b)
  );

  typedef struct {
    logic [7:0] data;
    int         stall;
    logic [7:0] exp_bus;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t tbl [4];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Wait (bounded) for VALID on instance a, return edges counted.
  task automatic wait_valid_a(output int lat);
    lat = 0;
    while (!valid_a && lat < 12) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic send_a(input vec_t v);
    int lat;
    bus_a = v.data;
    req_a = ~req_a;
    ready_a = 1'b0;
    wait_valid_a(lat);
    chk("lat_a", lat, 3);
    chk("cap_bus_a", int'(sync_a), int'(v.exp_bus));
    repeat (v.stall) begin
      @(negedge clk);
      chk("hold_valid_a", int'(valid_a), 1);
      chk("hold_bus_a", int'(sync_a), int'(v.exp_bus));
    end
    ready_a = 1'b1;
    @(negedge clk);
    ready_a = 1'b0;
    chk("done_valid_a", int'(valid_a), 0);
    chk("done_cnt_a", int'(cnt_a), int'(v.exp_cnt));
    chk("done_ack_a", int'(ack_a), int'(v.exp_cnt[0]));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] sent [$];
    logic [7:0] exp_w;
    int lat;
    int nsent;
    int bound;

    tbl[0] = '{8'h11, 0,  8'h11, 8'd2};
    tbl[1] = '{8'h22, 10, 8'h22, 8'd3};
    tbl[2] = '{8'hFF, 3,  8'hFF, 8'd4};
    tbl[3] = '{8'h00, 1,  8'h00, 8'd5};

    rst = 1'b1;
    {bus_a, req_a, ready_a, clr_a} = '0;
    {bus_b, req_b, ready_b, clr_b} = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", int'(valid_a), 0);
    chk("rst_bus", int'(sync_a), 0);
    chk("rst_cnt", int'(cnt_a), 0);
    chk("rst_ack", int'(ack_a), 0);
    rst = 1'b0;

    // Single transfer with READY held high.
    bus_a = 8'h3C;
    req_a = 1'b1;
    ready_a = 1'b1;
    @(negedge clk);
    chk("e1_valid", int'(valid_a), 0);
    @(negedge clk);
    chk("e2_valid", int'(valid_a), 0);
    @(negedge clk);
    chk("e3_valid", int'(valid_a), 1);
    chk("e3_bus", int'(sync_a), 8'h3C);
    chk("e3_busy", int'(busy_a), 1);
    @(negedge clk);
    chk("e4_valid", int'(valid_a), 0);
    chk("e4_ack", int'(ack_a), 1);
    chk("e4_cnt", int'(cnt_a), 1);
    ready_a = 1'b0;

    for (int i = 0; i < 4; i++)
      send_a(tbl[i]);

    // Overrun while holding 5A.
    bus_a = 8'h5A;
    req_a = ~req_a;
    wait_valid_a(lat);
    chk("ovr_cap", int'(sync_a), 8'h5A);
    bus_a = 8'h77;
    req_a = ~req_a;
    repeat (4) @(negedge clk);
    chk("ovr_set", int'(ovr_a), 1);
    chk("ovr_bus", int'(sync_a), 8'h5A);
    chk("ovr_valid", int'(valid_a), 1);
    chk("ovr_ack", int'(ack_a), 1);
    clr_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
    chk("ovr_clr", int'(ovr_a), 0);
    req_a = ~req_a;
    @(negedge clk);
    @(negedge clk);
    clr_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
    chk("ovr_set_wins", int'(ovr_a), 1);
    clr_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
    chk("ovr_clr2", int'(ovr_a), 0);
    // READY and a new edge on the same cycle.
    req_a = ~req_a;
    @(negedge clk);
    @(negedge clk);
    ready_a = 1'b1;
    @(negedge clk);
    ready_a = 1'b0;
    chk("coin_valid", int'(valid_a), 0);
    chk("coin_cnt", int'(cnt_a), 6);
    chk("coin_ack", int'(ack_a), 0);
    chk("coin_ovr", int'(ovr_a), 1);
    repeat (4) @(negedge clk);
    chk("coin_lost", int'(valid_a), 0);
    chk("coin_bus", int'(sync_a), 8'h5A);

    // Asynchronous reset in the middle of HOLD.
    bus_a = 8'hA5;
    req_a = ~req_a;
    wait_valid_a(lat);
    chk("pre_rst_bus", int'(sync_a), 8'hA5);
    #2;
    rst = 1'b1;
    req_a = 1'b0;
    #1;
    chk("arst_bus", int'(sync_a), 0);
    chk("arst_valid", int'(valid_a), 0);
    chk("arst_busy", int'(busy_a), 0);
    chk("arst_ack", int'(ack_a), 0);
    chk("arst_ovr", int'(ovr_a), 0);
    chk("arst_cnt", int'(cnt_a), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", int'(valid_a), 0);

    // 256 words, counter wraps to zero.
    ready_a = 1'b1;
    for (int i = 0; i < 256; i++) begin
      bus_a = 8'(i);
      req_a = ~req_a;
      wait_valid_a(lat);
      chk("wrap_word", int'(sync_a), i);
      @(negedge clk);
      chk("wrap_cnt", int'(cnt_a), (i + 1) % 256);
    end
    ready_a = 1'b0;
    chk("wrap_cnt0", int'(cnt_a), 0);
    chk("wrap_ack0", int'(ack_a), 0);
    chk("wrap_ovr0", int'(ovr_a), 0);

    // Random source on instance b; source waits for ACK parity.
    nsent = 0;
    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      exp_w = 8'($urandom);
      sent.push_back(exp_w);
      bus_b = exp_w;
      req_b = ~req_b;
      lat = 0;
      while (!valid_b && lat < 12) begin
        @(negedge clk);
        lat++;
      end
      chk("rnd_lat", lat, 4);
      exp_w = sent.pop_front();
      chk("rnd_word", int'(sync_b), int'(exp_w));
      repeat ($urandom_range(0, 4)) begin
        @(negedge clk);
        chk("rnd_hold", int'(sync_b), int'(exp_w));
      end
      ready_b = 1'b1;
      @(negedge clk);
      ready_b = 1'b0;
      nsent++;
      bound = 0;
      while (ack_b != 1'(nsent) && bound < 8) begin
        @(negedge clk);
        bound++;
      end
      chk("rnd_ack", int'(ack_b), nsent % 2);
      chk("rnd_cnt", int'(cnt_b), nsent % 256);
    end
    chk("rnd_ovr", int'(ovr_b), 0);
    chk("rnd_empty", sent.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_sync_ctrl.md
Name: data_sync_ctrl

Overview:
Destination-side controller for a multi-bit clock-domain crossing using a 2-phase toggle handshake.
- Synchronises the source's request toggle through a NUM_STAGES flop chain and detects its edges.
- Captures the quasi-static source bus and presents it on a valid/ready interface.
- Returns an acknowledge toggle to the source and flags protocol overruns.
- Sits between the UART/register-file domain crossing and the consuming logic in the CLK domain.

Parameters:
NUM_STAGES, 2, synchroniser depth for REQ_TGL; legal range 2..4.
BUS_WIDTH, 8, width of the crossed data bus.
CNT_WIDTH, 8, width of the completed-transfer counter.

Ports:
CLK  in  1  destination clock; all state on rising edge.
RST  in  1  asynchronous, active-high reset.
UNSYNC_BUS  in  BUS_WIDTH  source-domain data; source holds it stable from its REQ_TGL toggle until it sees ACK_TGL match.
REQ_TGL  in  1  source request; one toggle per new word; asynchronous to CLK.
SYNC_BUS  out  BUS_WIDTH  captured data, registered.
VALID  out  1  SYNC_BUS holds an unconsumed word.
READY  in  1  consumer accepts the word when VALID&READY at a rising edge.
ACK_TGL  out  1  acknowledge toggle back to the source, registered.
BUSY  out  1  high in HOLD state.
OVERRUN  out  1  sticky protocol-violation flag.
CLR_OVR  in  1  synchronous clear of OVERRUN.
XFER_CNT  out  CNT_WIDTH  count of completed transfers; wraps.

Behaviour:
- Reset (async, RST=1) sets all of these to 0: sync chain, req_d, state=IDLE, SYNC_BUS, VALID, ACK_TGL, BUSY, OVERRUN, XFER_CNT. Reset mid-transfer discards the held word with no ACK; source-side reset is system-level.
- Synchroniser: req_s = REQ_TGL after NUM_STAGES flops.
- Edge detect: req_d registers req_s; req_edge = req_s ^ req_d, combinational.
- Latency: with REQ_TGL changed before edge E1, req_s changes after E_NUM_STAGES and capture happens at E_(NUM_STAGES+1). VALID is high from E_(NUM_STAGES+1), i.e. NUM_STAGES+1 edges.
- FSM IDLE (VALID=0):
  - On req_edge: SYNC_BUS <= UNSYNC_BUS, VALID <= 1, go to HOLD.
  - Otherwise stay in IDLE; SYNC_BUS keeps its last value.
- FSM HOLD (VALID=1, BUSY=1):
  - On READY=1: VALID <= 0, ACK_TGL <= ~ACK_TGL, XFER_CNT <= XFER_CNT+1 (mod 2^CNT_WIDTH), go to IDLE.
  - On READY=0: hold; SYNC_BUS is stable.
  - Minimum VALID width is one cycle; back-to-back words are limited by source round trip.
- Overrun: req_edge while in HOLD sets OVERRUN <= 1 and discards the new word; SYNC_BUS is unchanged and no extra ACK is sent.
  - If req_edge and READY=1 coincide in HOLD, the current word completes (ACK toggles), the edge counts as overrun, and its word is lost.
- OVERRUN is cleared by CLR_OVR=1. If a set and CLR_OVR occur in the same cycle, set wins.
- ACK_TGL changes only on a consumed word, so it always equals the parity of XFER_CNT[0].
- READY is ignored in IDLE.

Decomposition:
- Package data_sync_pkg:
  - state encoding ST_IDLE=1'b0, ST_HOLD=1'b1;
  - localparams NUM_STAGES_MIN=2, NUM_STAGES_MAX=4;
  - elaboration check on NUM_STAGES range.
- Sub-module req_sync_chain (NUM_STAGES, width 1, async active-high reset) instantiated once for REQ_TGL. Edge detect and FSM stay in the top module.

Test Plan:
1. Reset: assert RST mid-HOLD with SYNC_BUS=8'hA5 -> all outputs 0 immediately (async), state IDLE, no ACK_TGL toggle.
2. Single transfer, NUM_STAGES=2, READY=1: UNSYNC_BUS=8'h3C, toggle REQ_TGL before E1 -> VALID rises after E3 with SYNC_BUS=8'h3C; after E4 VALID=0, ACK_TGL=1, XFER_CNT=1.
3. Backpressure: READY=0 for 10 cycles after VALID -> VALID and SYNC_BUS stable; READY=1 -> one transfer, ACK toggles once.
4. Overrun: while in HOLD, toggle REQ_TGL with bus 8'h77 -> OVERRUN=1, SYNC_BUS keeps old value; CLR_OVR=1 same cycle as a new overrun -> OVERRUN stays 1; CLR_OVR alone -> 0.
5. Wrap: 256 handshaked transfers of incrementing data -> every word received in order, XFER_CNT returns to 0, ACK_TGL=0, OVERRUN=0.
6. Random glitch-free toggle timing with a source model waiting on ACK_TGL, NUM_STAGES=3 -> scoreboard match, VALID-to-capture latency exactly 4 edges from first sampling edge.
